calc_display_scan: RTL and testbench

- Display controller for the calculator datapath.
- Each cycle it samples the calculator's digit/position outputs (dig, pos) and its status, and mirrors the digits into an 8-entry digit buffer.
- It time-multiplexes the buffer onto a common-anode 8-digit 7-segment display, with leading-digit blanking, an error banner and a busy indication.
- It sits between the calculator core and the FPGA board display pins.

---
 rtl/calc_display_scan.sv | 150 +++++++++++++++
 tb/tb_calc_display_scan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan.sv
// calc_display_scan: mirrors the calculator's digit outputs into an 8-entry
// buffer and multiplexes that buffer onto a common-anode 8-digit 7-segment
// display. It adds leading-digit blanking, an "Erro" banner while the core
// reports an error, and an all-dash pattern while the core is busy.
module calc_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int NUM_DIG  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] pos,
    input  logic [3:0] dig,
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic [2:0] scan_idx
);

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DIG_LIMIT = 4'(NUM_DIG);

    // Active-low {g,f,e,d,c,b,a} glyphs that are not plain digits
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;

    typedef enum logic [1:0] {
        MODE_DIGITS = 2'd0,
        MODE_ERR    = 2'd1,
        MODE_BUSY   = 2'd2
    } mode_t;

    // Digit value to active-low segment pattern; 10..15 are shown blank
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    logic [PW-1:0]              prescaler;
    logic [3:0]                 digit_buf [NUM_DIG];
    logic [2:0]                 hi_pos;
    logic                       prev_err;
    logic                       is_err;
    logic                       wipe;
    logic                       capture;
    mode_t                      mode;
    logic [NUM_DIG-1:0][6:0]    glyph;

    // Leaving the error state wipes stale digits; clear does the same on demand.
    // The buffer is frozen while the core reports an error.
    assign is_err  = (status == 2'd0);
    assign wipe    = clear || (prev_err && !is_err);
    assign capture = !is_err && (pos < DIG_LIMIT);

    // Display mode follows the live status so a change shows on the next cycle
    always_comb begin
        mode = MODE_DIGITS;
        if (status == 2'd0) begin
            mode = MODE_ERR;
        end else if (status == 2'd2) begin
            mode = MODE_BUSY;
        end
    end

    // Remember whether the previous cycle was an error, to detect its exit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_err <= 1'b0;
        end else begin
            prev_err <= is_err;
        end
    end

    // Digit buffer: wipe has priority over a same-cycle capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                digit_buf[i] <= '0;
            end
        end else if (wipe) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                digit_buf[i] <= '0;
            end
        end else if (capture) begin
            digit_buf[pos[2:0]] <= dig;
        end
    end

    // Highest position written since the last wipe; everything above it is blanked
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_pos <= '0;
        end else if (wipe) begin
            hi_pos <= '0;
        end else if (capture && (pos[2:0] > hi_pos)) begin
            hi_pos <= pos[2:0];
        end
    end

    // Dwell prescaler; each wrap moves the scan to the next digit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            scan_idx  <= scan_idx + 3'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Per-position glyph selection for the current mode
    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_glyph
        localparam logic [6:0] BANNER = (gi == 3) ? SEG_E :
                                        (gi == 2 || gi == 1) ? SEG_R :
                                        (gi == 0) ? SEG_O : SEG_BLANK;
        assign glyph[gi] = (mode == MODE_ERR)      ? BANNER :
                           (mode == MODE_BUSY)     ? SEG_DASH :
                           (3'(gi) <= hi_pos)      ? decode(digit_buf[gi]) :
                                                     SEG_BLANK;
    end

    // Registered pin drivers: one cycle behind scan_idx, buffer and status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(8'b1 << scan_idx);
            seg <= glyph[scan_idx];
        end
    end

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_calc_display_scan;

    localparam int SD = 4;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       clear  = 1'b0;
    logic [3:0] pos    = 4'd0;
    logic [3:0] dig    = 4'd0;
    logic [1:0] status = 2'd1;
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] scan_idx;

    int total = 0;
    int bad   = 0;

    calc_display_scan #(.SCAN_DIV(SD), .NUM_DIG(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .pos      (pos),
        .dig      (dig),
        .status   (status),
        .an       (an),
        .seg      (seg),
        .scan_idx (scan_idx)
    );

    always #5 clock = ~clock;

    // Behavioural model state: digit contents, highest written position,
    // previous-cycle error flag and number of clock edges since reset.
    int m_buf [8];
    int m_hi   = 0;
    bit m_prev = 1'b0;
    int m_n    = 0;

    function automatic logic [6:0] glyph_of(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int idx, input logic [1:0] st);
        if (st == 2'd0) begin
            case (idx)
                3:       return 7'h06;
                2, 1:    return 7'h2F;
                0:       return 7'h23;
                default: return 7'h7F;
            endcase
        end
        if (st == 2'd2) return 7'h3F;
        if (idx <= m_hi) return glyph_of(m_buf[idx]);
        return 7'h7F;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge
    always @(posedge clock) begin
        int         idx;
        logic [7:0] ea;
        logic [6:0] es;
        #1;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_buf[i] = 0;
            m_hi   = 0;
            m_prev = 1'b0;
            m_n    = 0;
            check("reset_an", an, 8'hFF);
            check("reset_seg", seg, 7'h7F);
            check("reset_scan_idx", scan_idx, 0);
        end else begin
            idx = (m_n / SD) % 8;
            ea  = ~(8'b1 << idx);
            es  = expect_seg(idx, status);
            if (clear || (m_prev && status != 2'd0)) begin
                for (int i = 0; i < 8; i++) m_buf[i] = 0;
                m_hi = 0;
            end else if (status != 2'd0 && pos < 4'd8) begin
                m_buf[pos] = int'(dig);
                if (int'(pos) > m_hi) m_hi = int'(pos);
            end
            m_prev = (status == 2'd0);
            m_n++;
            check("an", an, ea);
            check("seg", seg, es);
            check("scan_idx", scan_idx, (m_n / SD) % 8);
        end
    end

    // Wait for digit p to be lit and compare its segments with a literal
    task automatic check_pos(input int p, input logic [6:0] exp, input string name);
        logic [7:0] want_an;
        bit         found;
        want_an = ~(8'b1 << p);
        found   = 1'b0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clock);
            if (an == want_an) found = 1'b1;
        end
        if (!found) begin
            check({name, "_an_timeout"}, an, want_an);
        end else begin
            check(name, seg, exp);
            $display("check %s: pos %0d seg %02h (want %02h)", name, p, seg, exp);
        end
    endtask

    task automatic write(input int p, input int d);
        pos = 4'(p);
        dig = 4'(d);
        @(negedge clock);
    endtask

    initial begin
        bit found;

        // Reset state, then the idle scan showing "0" on position 0 only
        @(negedge clock);
        check("lit_reset_an", an, 8'hFF);
        check("lit_reset_seg", seg, 7'h7F);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("lit_first_an", an, 8'hFE);
        check_pos(0, 7'h40, "idle_pos0");
        check_pos(3, 7'h7F, "idle_pos3");

        // Three digits written while ready
        write(0, 1);
        write(1, 2);
        write(2, 3);
        pos = 4'd15;
        check_pos(0, 7'h79, "digits_pos0");
        check_pos(1, 7'h24, "digits_pos1");
        check_pos(2, 7'h30, "digits_pos2");
        check_pos(3, 7'h7F, "digits_pos3");
        check_pos(7, 7'h7F, "digits_pos7");

        // Error banner while a write is being attempted
        status = 2'd0;
        pos    = 4'd0;
        dig    = 4'd7;
        check_pos(3, 7'h06, "err_pos3");
        check_pos(2, 7'h2F, "err_pos2");
        check_pos(1, 7'h2F, "err_pos1");
        check_pos(0, 7'h23, "err_pos0");
        check_pos(5, 7'h7F, "err_pos5");
        pos    = 4'd15;
        status = 2'd1;
        check_pos(0, 7'h40, "errexit_pos0");
        check_pos(1, 7'h7F, "errexit_pos1");
        check_pos(2, 7'h7F, "errexit_pos2");

        // Busy dashes, then the digits come back
        write(0, 1);
        write(1, 2);
        pos    = 4'd15;
        status = 2'd2;
        check_pos(0, 7'h3F, "busy_pos0");
        check_pos(4, 7'h3F, "busy_pos4");
        status = 2'd1;
        check_pos(1, 7'h24, "ready_pos1");
        check_pos(0, 7'h79, "ready_pos0");

        // Clear beats a same-cycle write
        clear = 1'b1;
        write(5, 9);
        clear = 1'b0;
        pos   = 4'd15;
        check_pos(5, 7'h7F, "clear_pos5");
        check_pos(0, 7'h40, "clear_pos0");

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) status = 2'($urandom_range(0, 3));
            pos   = 4'($urandom_range(0, 9));
            dig   = 4'($urandom);
            clear = ($urandom_range(0, 40) == 0);
            @(negedge clock);
        end
        clear  = 1'b0;
        status = 2'd1;
        pos    = 4'd15;

        // Reset asserted mid-dwell while digit 5 is lit
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clock);
            if (scan_idx == 3'd5) found = 1'b1;
        end
        if (!found) check("reach_idx5", scan_idx, 5);
        #1 reset = 1'b1;
        #1;
        check("lit_midrst_an", an, 8'hFF);
        check("lit_midrst_seg", seg, 7'h7F);
        check("lit_midrst_idx", scan_idx, 0);
        $display("check mid-dwell reset: an %02h seg %02h idx %0d", an, seg, scan_idx);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("lit_restart_an", an, 8'hFE);
        check("lit_restart_idx", scan_idx, 0);
        check_pos(0, 7'h40, "restart_pos0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
